// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared FUNCT3 encodings, FSM state encoding, timeout default
//                and request-decode helpers for the memory access unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam int MEM_TIMEOUT_DEFAULT = 255;
    localparam int CNT_W               = 10;

    // Load/store size and sign encodings carried on FUNCT3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Unsigned variants only make sense for loads; everything else unlisted is reserved
    function automatic logic f3_is_illegal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return is_store;
            default:          return 1'b1;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Data-memory bus between the access unit (master) and the
//                memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;

    logic [31:0] dmem_addr;
    logic [31:0] dmem_writedata;
    logic [3:0]  dmem_byte_en;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_readdata;
    logic        dmem_busywait;

    modport master (
        output dmem_addr,
        output dmem_writedata,
        output dmem_byte_en,
        output dmem_read,
        output dmem_write,
        input  dmem_readdata,
        input  dmem_busywait
    );

    modport slave (
        input  dmem_addr,
        input  dmem_writedata,
        input  dmem_byte_en,
        input  dmem_read,
        input  dmem_write,
        output dmem_readdata,
        output dmem_busywait
    );

endinterface
`default_nettype wire

// File: rtl/mem_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_extend
//  Description : Selects the addressed byte/halfword lane of a memory word and
//                sign- or zero-extends it according to FUNCT3.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select: byte by full offset, halfword by offset bit 1
    always_comb begin
        w_byte = word_i[7:0];
        case (addr_lo_i)
            2'd0:    w_byte = word_i[7:0];
            2'd1:    w_byte = word_i[15:8];
            2'd2:    w_byte = word_i[23:16];
            default: w_byte = word_i[31:24];
        endcase
        w_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension by access type; reserved encodings never reach here but yield 0
    always_comb begin
        data_o = 32'h0;
        case (funct3_i)
            F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
            F3_H:    data_o = {{16{w_half[15]}}, w_half};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h0, w_byte};
            F3_HU:   data_o = {16'h0, w_half};
            default: data_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage load/store unit. Validates requests, drives the
//                data-memory bus with lane-aligned data and byte enables,
//                stalls the pipeline while memory is busy, extends load
//                results and aborts accesses that exceed MEM_TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       write_data_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    output logic [31:0]       load_data_o,
    output logic              busywait_o,
    output logic              access_fault_o,
    output logic              timeout_err_o,
    mem_access_unit_if.master dmem
);

    // Last counter value allowed in ACCESS; the access is abandoned on that edge
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        load_q, load_d;
    logic               terr_q, terr_d;

    logic               w_req;
    logic               w_illegal;
    logic               w_misaligned;
    logic               w_valid;
    logic               w_busy;
    logic               w_rd;
    logic               w_wr;
    logic               w_fault;
    logic [31:0]        w_ext;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;

    // Request classification from the (held) pipeline inputs
    always_comb begin
        w_req        = mem_read_i | mem_write_i;
        w_illegal    = (mem_read_i & mem_write_i) | f3_is_illegal(funct3_i, mem_write_i);
        w_misaligned = is_misaligned(funct3_i, alu_result_i[1:0]);
        w_valid      = w_req & ~w_illegal & ~w_misaligned;
    end

    // Lane enables and replicated store data, decoded on access size
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_result_i[1:0];
                w_wdata = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << alu_result_i[1:0];
                w_wdata = {2{write_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data_i;
            end
        endcase
    end

    mem_load_extend u_load_extend (
        .word_i    (dmem.dmem_readdata),
        .addr_lo_i (alu_result_i[1:0]),
        .funct3_i  (funct3_i),
        .data_o    (w_ext)
    );

    // Next-state and output decode. BUSYWAIT is released in the cycle the
    // access completes so the pipeline advances on the same edge that
    // registers LOAD_DATA.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        terr_d  = 1'b0;
        w_busy  = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_fault = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_fault = w_req & ~w_valid;
                if (w_valid) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    w_busy  = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_rd = mem_read_i;
                w_wr = mem_write_i;
                if (!dmem.dmem_busywait) begin
                    state_d = ST_DONE;
                    if (mem_read_i) begin
                        load_d = w_ext;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_DONE;
                    terr_d  = 1'b1;
                    load_d  = 32'h0;
                end else begin
                    w_busy = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, load result and timeout flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            load_q  <= 32'h0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            terr_q  <= terr_d;
        end
    end

    // Stall is also squashed by reset, since acceptance is combinational
    assign busywait_o          = w_busy & rst_n;
    assign access_fault_o      = w_fault;
    assign timeout_err_o       = terr_q;
    assign load_data_o         = load_q;

    assign dmem.dmem_addr      = {alu_result_i[31:2], 2'b00};
    assign dmem.dmem_writedata = w_wdata;
    assign dmem.dmem_byte_en   = (w_rd | w_wr) ? w_be : 4'b0000;
    assign dmem.dmem_read      = w_rd;
    assign dmem.dmem_write     = w_wr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit: table of single
//                transactions plus hand-written stall, timeout and reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic [31:0] load_data;
    logic        busywait;
    logic        access_fault;
    logic        timeout_err;

    logic        to_rd;
    logic        to_busy;
    logic [31:0] to_load;
    logic        to_busywait;
    logic        to_fault;
    logic        to_terr;

    int n_tests;
    int n_fail;

    mem_access_unit_if bus ();
    mem_access_unit_if bus_to ();

    assign bus.dmem_readdata    = mem_rdata;
    assign bus.dmem_busywait    = mem_busy;
    assign bus_to.dmem_readdata = mem_rdata;
    assign bus_to.dmem_busywait = to_busy;

    mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_result_i   (alu_result),
        .write_data_i   (write_data),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .funct3_i       (funct3),
        .load_data_o    (load_data),
        .busywait_o     (busywait),
        .access_fault_o (access_fault),
        .timeout_err_o  (timeout_err),
        .dmem           (bus.master)
    );

    mem_access_unit #(.MEM_TIMEOUT(4)) dut_to (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_result_i   (alu_result),
        .write_data_i   (write_data),
        .mem_read_i     (to_rd),
        .mem_write_i    (1'b0),
        .funct3_i       (funct3),
        .load_data_o    (to_load),
        .busywait_o     (to_busywait),
        .access_fault_o (to_fault),
        .timeout_err_o  (to_terr),
        .dmem           (bus_to.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] exp_load;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_vec(input vec_t v);
        @(negedge clk);
        mem_read   = v.rd;
        mem_write  = v.wr;
        funct3     = v.f3;
        alu_result = v.addr;
        write_data = v.wdata;
        mem_rdata  = v.rdata;
        #1;
        check("fault", 32'(access_fault), 32'(v.fault));
        check("busy_idle", 32'(busywait), 32'(!v.fault));
        if (!v.fault) begin
            @(negedge clk); #1;
            check("dmem_read", 32'(bus.dmem_read), 32'(v.rd));
            check("dmem_write", 32'(bus.dmem_write), 32'(v.wr));
            check("dmem_addr", bus.dmem_addr, {v.addr[31:2], 2'b00});
            check("busy_access", 32'(busywait), 32'd0);
            if (v.wr) begin
                check("byte_en", 32'(bus.dmem_byte_en), 32'(v.exp_be));
                check("wdata", bus.dmem_writedata, v.exp_wdata);
            end
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            check("load_done", load_data, v.exp_load);
            check("busy_done", 32'(busywait), 32'd0);
            @(negedge clk); #1;
            check("idle_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
            check("load_hold", load_data, v.exp_load);
        end else begin
            @(negedge clk); #1;
            check("fault_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
            check("fault_busy", 32'(busywait), 32'd0);
            check("fault_load", load_data, v.exp_load);
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        int bw_cnt;
        int st_cnt;
        int te_cnt;

        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        alu_result = 32'h0;
        write_data = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        mem_rdata  = 32'h0;
        mem_busy   = 1'b0;
        to_rd      = 1'b0;
        to_busy    = 1'b0;

        //            rd    wr    f3      addr          wdata         rdata         flt   exp_load      be       exp_wdata
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h0,       1'b0, 32'hFFFF_FF80, 4'b0010, 32'hABAB_ABAB};
        vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'h0,        1'b1, 32'hFFFF_FF80, 4'b0000, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_5002, 32'h0,        32'h8001_7FFF, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h0000_6001, 32'h0,        32'h1234_F056, 1'b0, 32'h0000_00F0, 4'b0010, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_8002, 32'h1234_5678, 32'h0,       1'b0, 32'hDEAD_BEEF, 4'b1100, 32'h5678_5678};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_9000, 32'hCAFE_F00D, 32'h0,       1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_9001, 32'h0,        32'h0,        1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_9000, 32'h0,        32'h0,        1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h0000_9000, 32'h0,        32'h0,        1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_9000, 32'h0,        32'h0,        1'b1, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_A000, 32'h0,        32'h0000_007F, 1'b0, 32'h0000_007F, 4'b0001, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b101, 32'h0000_A000, 32'h0,        32'hFFFF_8000, 1'b0, 32'h0000_8000, 4'b0011, 32'h0};

        // Reset state before any clock edge
        #2;
        check("rst_load", load_data, 32'h0);
        check("rst_busy", 32'(busywait), 32'd0);
        check("rst_strobe", 32'({bus.dmem_read, bus.dmem_write}), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_vec(vecs[i]);
        end

        // LHU with memory busy for 5 ACCESS cycles
        @(negedge clk);
        mem_read   = 1'b1;
        funct3     = 3'b101;
        alu_result = 32'h0000_2002;
        mem_rdata  = 32'hBEEF_0000;
        mem_busy   = 1'b1;
        bw_cnt     = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) mem_busy = 1'b0;
            #1;
            if (busywait) bw_cnt++;
            if (c >= 1 && c <= 5) check("stall_strobe", 32'(bus.dmem_read), 32'd1);
            if (c == 7) begin
                check("stall_load", load_data, 32'h0000_BEEF);
                check("stall_terr", 32'(timeout_err), 32'd0);
                mem_read = 1'b0;
            end
            @(negedge clk);
        end
        check("stall_busy_cycles", 32'(bw_cnt), 32'd6);

        // Timeout instance: a good load first so the abort visibly clears LOAD_DATA
        to_rd      = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_B004;
        mem_rdata  = 32'h1234_5678;
        to_busy    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        to_rd = 1'b0;
        #1;
        check("to_preload", to_load, 32'h1234_5678);
        @(negedge clk);
        to_rd   = 1'b1;
        to_busy = 1'b1;
        st_cnt  = 0;
        te_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus_to.dmem_read) st_cnt++;
            if (to_terr) te_cnt++;
            if (c == 5) begin
                check("to_terr", 32'(to_terr), 32'd1);
                check("to_load_zero", to_load, 32'h0);
                check("to_busy_done", 32'(to_busywait), 32'd0);
                to_rd = 1'b0;
            end
            @(negedge clk);
        end
        check("to_strobe_cycles", 32'(st_cnt), 32'd4);
        check("to_terr_cycles", 32'(te_cnt), 32'd1);
        to_busy = 1'b0;

        // Reset in the middle of an ACCESS
        @(negedge clk);
        mem_read   = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_C000;
        mem_busy   = 1'b1;
        @(negedge clk); #1;
        check("mid_access_strobe", 32'(bus.dmem_read), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_strobe", 32'(bus.dmem_read), 32'd0);
        check("rst_async_busy", 32'(busywait), 32'd0);
        check("rst_async_load", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_idle_strobe", 32'(bus.dmem_read), 32'd0);
        check("post_rst_idle_accept", 32'(busywait), 32'd1);
        mem_read = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk); #1;
        check("post_rst_no_done", 32'(timeout_err), 32'd0);
        check("post_rst_load", load_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, gives the maximum cycles in ACCESS before abort (range 1..1023).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 ALU_RESULT  in  32  byte address from the EX-stage ALU.
REQ-006 WRITE_DATA  in  32  store data (rs2).
REQ-007 MEM_READ  in  1  load request.
REQ-008 MEM_WRITE  in  1  store request.
REQ-009 FUNCT3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 DMEM_ADDR  out  32  word address, ALU_RESULT with [1:0] forced to 0.
REQ-011 DMEM_WRITEDATA  out  32  lane-aligned store data.
REQ-012 DMEM_BYTE_EN  out  4  byte-lane enables.
REQ-013 DMEM_READ / DMEM_WRITE  out  1 each  memory strobes.
REQ-014 DMEM_READDATA  in  32  memory read word.
REQ-015 DMEM_BUSYWAIT  in  1  memory not ready.
REQ-016 LOAD_DATA  out  32  extended load result, registered.
REQ-017 BUSYWAIT  out  1  pipeline stall request.
REQ-018 ACCESS_FAULT  out  1  misaligned or illegal access, combinational.
REQ-019 TIMEOUT_ERR  out  1  access aborted on timeout, registered.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-021 A valid request is exactly one of MEM_READ/MEM_WRITE high, with a legal FUNCT3 and an aligned address.
REQ-022 In IDLE with a valid request, the FSM SHALL move to ACCESS and assert BUSYWAIT combinationally in that same cycle.
REQ-023 ACCESS SHALL drive DMEM_READ or DMEM_WRITE and hold BUSYWAIT=1 until the first edge with DMEM_BUSYWAIT=0, then move to DONE.
REQ-024 On that edge, a load SHALL capture DMEM_READDATA, lane-select it by ALU_RESULT[1:0], extend it by FUNCT3, and write it into LOAD_DATA.
REQ-025 DONE SHALL last exactly 1 cycle with BUSYWAIT=0, LOAD_DATA valid and requests ignored, then return to IDLE.
REQ-026 The minimum load latency from IDLE acceptance to LOAD_DATA valid SHALL be 2 edges.
REQ-027 Byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111. Store data replicated: byte x4, half x2.
REQ-028 Misalignment: H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-029 Illegal cases: FUNCT3 011/110/111; BU/HU on a store; MEM_READ and MEM_WRITE both high.
REQ-030 Any misaligned or illegal request SHALL assert ACCESS_FAULT in IDLE, issue no DMEM strobe, keep BUSYWAIT=0, and leave the FSM in IDLE.
REQ-031 A cycle counter SHALL clear on ACCESS entry; when it reaches MEM_TIMEOUT, strobes drop, the FSM enters DONE, and TIMEOUT_ERR=1 with LOAD_DATA=0 for that cycle.
REQ-032 Inputs are held stable by the pipeline while BUSYWAIT=1; DMEM outputs SHALL be decoded from the held inputs.
REQ-033 LOAD_DATA SHALL hold its value outside DONE; for stores it is unchanged.

Reset
REQ-034 RESET low SHALL immediately force: state IDLE, LOAD_DATA 0, counter 0, TIMEOUT_ERR 0, DMEM_READ/DMEM_WRITE 0, BUSYWAIT 0.
REQ-035 Reset asserted mid-ACCESS SHALL abort the transaction with no DONE cycle.

Structure
REQ-036 A shared package SHALL hold the FUNCT3 encodings, the state encodings (IDLE/ACCESS/DONE) and the MEM_TIMEOUT default.
REQ-037 Lane select and sign/zero extension SHALL be a combinational sub-module, mem_load_extend.

Verification
REQ-038 LB, addr 0x1003, memory word 0x80FF_1234, DMEM_BUSYWAIT low -> LOAD_DATA=0xFFFF_FF80 after 2 edges; BUSYWAIT high exactly 1 cycle.
REQ-039 LHU, addr 0x2002, word 0xBEEF_0000, DMEM_BUSYWAIT high 5 cycles -> BUSYWAIT high 6 cycles, LOAD_DATA=0x0000_BEEF.
REQ-040 SB, addr 0x3001, WRITE_DATA 0x0000_00AB -> DMEM_BYTE_EN=0010, DMEM_WRITEDATA=0xABAB_ABAB, DMEM_ADDR=0x3000.
REQ-041 LW, addr 0x4002 -> ACCESS_FAULT=1, no DMEM strobe, BUSYWAIT=0.
REQ-042 MEM_TIMEOUT=4, DMEM_BUSYWAIT stuck high -> strobe drops after 4 cycles, TIMEOUT_ERR pulses 1 cycle, LOAD_DATA=0.
REQ-043 RESET low during ACCESS -> DMEM_READ=0 and BUSYWAIT=0 without waiting for CLK; after release the FSM is in IDLE.
